// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
// Shared types and constants for the two-master memory arbiter.
//   mem_arb_state_t    : arbiter sequencer states (IDLE, BUSY)
//   MEM_ARB_ABORT_DATA : read data returned to a master on a timeout abort
//   mem_req_t          : one master's request bundle, used for mux selection
// -----------------------------------------------------------------------------
package mem_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mem_arb_state_t;

  localparam logic [31:0] MEM_ARB_ABORT_DATA = 32'hDEAD_BEEF;

  typedef struct packed {
    logic        valid;
    logic        instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_req_t;

endpackage

// File: rtl/mem_arb_rr2.sv
// -----------------------------------------------------------------------------
// mem_arb_rr2
// Two-input round-robin picker. Remembers which master completed last and,
// on a tie, picks the other one. After reset master 0 wins the first tie.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   req[1:0]   : request vector (bit X = master X valid)
//   update     : strobe, records upd_idx as the last served master
//   upd_idx    : index of the master whose transaction just finished
//   winner     : index of the master to grant (meaningful only if req != 0)
// -----------------------------------------------------------------------------
module mem_arb_rr2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       upd_idx,
  output logic       winner
);

  logic last_grant;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of always-block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant <= 1'b1;
    end else if (update) begin
      last_grant <= upd_idx;
    end
  end

  // NOTE: the output gets a default before any branch so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    winner = 1'b0;
    if (req == 2'b11) begin
      winner = ~last_grant;
    end else begin
      winner = req[1];
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Grant-locked round-robin arbiter sharing one PicoRV32-native memory slave
// between the CPU (master 0) and the loader/debug port (master 1).
// A request seen in IDLE is granted at the clock edge; the granted master's
// request is then muxed straight to the slave until s_ready, after which the
// arbiter spends one cycle in IDLE before the next grant.
//
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   m0_* / m1_*          : master request (valid, instr, addr, wdata, wstrb)
//                          and response (ready pulse, rdata)
//   s_*                  : slave request out, s_ready / s_rdata in
//   grant                : owner of the current or last transaction
//   busy                 : high while a transaction is in flight
//   timeout_err          : sticky timeout abort flag
//
// Build option: define MEM_ARB_TIMEOUT_EN to abort a transaction whose slave
// has not answered within TIMEOUT_CYCLES busy cycles. Without it the arbiter
// waits indefinitely and timeout_err is tied low.
// -----------------------------------------------------------------------------
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_valid,
  input  logic        m0_instr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic        m1_instr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic        s_instr,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic        grant,
  output logic        busy,
  output logic        timeout_err
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("mem_arbiter: TIMEOUT_CYCLES must be at least 2");
  end

  mem_arb_state_t state;
  mem_req_t       req0, req1, sel;
  logic           winner;
  logic           abort;
  logic           done;

  assign req0 = {m0_valid, m0_instr, m0_addr, m0_wdata, m0_wstrb};
  assign req1 = {m1_valid, m1_instr, m1_addr, m1_wdata, m1_wstrb};
  assign sel  = grant ? req1 : req0;

  assign busy = (state == BUSY);
  // A transaction ends on the slave's ready or, when enabled, on a timeout.
  assign done = busy & (s_ready | abort);

  mem_arb_rr2 u_rr2 (
    .clk     (clk),
    .reset   (reset),
    .req     ({m1_valid, m0_valid}),
    .update  (done),
    .upd_idx (grant),
    .winner  (winner)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      grant <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_valid | m1_valid) begin
            state <= BUSY;
            grant <= winner;
          end
        end
        BUSY: begin
          if (done) begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  // Slave side: the granted request passes through while busy; everything is
  // held at zero in IDLE so the slave never sees stale address/data.
  assign s_valid = busy & sel.valid & ~abort;
  assign s_instr = busy & sel.instr;
  assign s_addr  = busy ? sel.addr  : 32'h0;
  assign s_wdata = busy ? sel.wdata : 32'h0;
  assign s_wstrb = busy ? sel.wstrb : 4'h0;

  // Master side: only the granted master ever sees ready.
  assign m0_ready = done & ~grant;
  assign m1_ready = done & grant;
  assign m0_rdata = abort ? MEM_ARB_ABORT_DATA : s_rdata;
  assign m1_rdata = abort ? MEM_ARB_ABORT_DATA : s_rdata;

`ifdef MEM_ARB_TIMEOUT_EN
  logic [15:0] busy_cnt;
  logic        timeout_q;

  // Counts busy cycles of the current transaction; zero in the first one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_cnt <= 16'h0;
    end else if (!busy) begin
      busy_cnt <= 16'h0;
    end else begin
      busy_cnt <= busy_cnt + 16'h1;
    end
  end

  // A slave ready in the last allowed cycle still completes normally.
  assign abort = busy & ~s_ready & (busy_cnt == 16'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeout_q <= 1'b0;
    end else if (abort) begin
      timeout_q <= 1'b1;
    end
  end

  assign timeout_err = timeout_q;
`else
  assign abort       = 1'b0;
  assign timeout_err = 1'b0;
`endif

endmodule
